// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU (port A) and load (port B) writebacks onto the single register_set write port.
// Latency: a transfer at edge E raises write_en after edge E+1, so register_set writes at edge E+2.
// Backpressure: x_ready = slot empty or slot granted this cycle (registered state only); a losing slot holds its entry.
// Build option: define WB_RR_EN for round-robin between two full slots; default is fixed priority B over A.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        write_en,
  output logic [4:0]  WriteAdd,
  output logic [31:0] Reg_WriteData,
  input  logic [4:0]  ReadAdd1,
  input  logic [4:0]  ReadAdd2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        busy,
  output logic [15:0] wr_count
);

  // Holding slots, one per requester.
  logic        a_full_q, a_full_d;
  logic [4:0]  a_addr_q, a_addr_d;
  logic [31:0] a_data_q, a_data_d;
  logic        b_full_q, b_full_d;
  logic [4:0]  b_addr_q, b_addr_d;
  logic [31:0] b_data_q, b_data_d;

  // Set when slot A holds the older entry; only consulted when both slots target the same register.
  logic        a_older_q, a_older_d;

  // Registered write port toward register_set.
  logic        write_en_q, write_en_d;
  logic [4:0]  write_add_q, write_add_d;
  logic [31:0] write_data_q, write_data_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic grant_a, grant_b;
  logic a_fill, b_fill;
  logic policy_b;

`ifdef WB_RR_EN
  logic rr_last_a_q, rr_last_a_d;

  // Round-robin: the port not granted most recently wins a both-full contest.
  always_comb begin
    policy_b    = rr_last_a_q;
    rr_last_a_d = rr_last_a_q;
    if (grant_a) begin
      rr_last_a_d = 1'b1;
    end else if (grant_b) begin
      rr_last_a_d = 1'b0;
    end
  end

  // Last-grant pointer; reset says A went last so B is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_a_q <= 1'b1;
    end else begin
      rr_last_a_q <= rr_last_a_d;
    end
  end
`else
  // Fixed priority: B (loads) always beats A in a both-full contest.
  assign policy_b = 1'b1;
`endif

  // Pick exactly one full slot; same-register pairs drain oldest first to keep write order.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_addr_q == b_addr_q) begin
        grant_a = a_older_q;
        grant_b = !a_older_q;
      end else begin
        grant_a = !policy_b;
        grant_b = policy_b;
      end
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  assign a_ready = !a_full_q || grant_a;
  assign b_ready = !b_full_q || grant_b;

  // Writes to x0 are accepted but never occupy a slot.
  assign a_fill = a_valid && a_ready && (a_addr != 5'd0);
  assign b_fill = b_valid && b_ready && (b_addr != 5'd0);

  // Slot drain/refill, age tracking and the next write-port contents.
  always_comb begin
    a_full_d     = a_full_q;
    a_addr_d     = a_addr_q;
    a_data_d     = a_data_q;
    b_full_d     = b_full_q;
    b_addr_d     = b_addr_q;
    b_data_d     = b_data_q;
    a_older_d    = a_older_q;
    write_en_d   = grant_a || grant_b;
    write_add_d  = write_add_q;
    write_data_d = write_data_q;
    wr_count_d   = wr_count_q + {15'd0, write_en_q};

    if (grant_a) begin
      a_full_d     = 1'b0;
      write_add_d  = a_addr_q;
      write_data_d = a_data_q;
    end else if (grant_b) begin
      b_full_d     = 1'b0;
      write_add_d  = b_addr_q;
      write_data_d = b_data_q;
    end

    if (a_fill) begin
      a_full_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_data;
    end
    if (b_fill) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end

    // A simultaneous fill counts B as older; a lone B fill leaves A older.
    if (a_fill) begin
      a_older_d = 1'b0;
    end else if (b_fill) begin
      a_older_d = 1'b1;
    end
  end

  // State registers; reset empties both slots and silences the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q     <= 1'b0;
      a_addr_q     <= 5'd0;
      a_data_q     <= 32'd0;
      b_full_q     <= 1'b0;
      b_addr_q     <= 5'd0;
      b_data_q     <= 32'd0;
      a_older_q    <= 1'b0;
      write_en_q   <= 1'b0;
      write_add_q  <= 5'd0;
      write_data_q <= 32'd0;
      wr_count_q   <= 16'd0;
    end else begin
      a_full_q     <= a_full_d;
      a_addr_q     <= a_addr_d;
      a_data_q     <= a_data_d;
      b_full_q     <= b_full_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      a_older_q    <= a_older_d;
      write_en_q   <= write_en_d;
      write_add_q  <= write_add_d;
      write_data_q <= write_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign write_en      = write_en_q;
  assign WriteAdd      = write_add_q;
  assign Reg_WriteData = write_data_q;
  assign wr_count      = wr_count_q;
  assign busy          = a_full_q || b_full_q || write_en_q;

  // Hazard flags for the read ports: a matching write is still queued or on the write port.
  always_comb begin
    pend_hit1 = (ReadAdd1 != 5'd0) &&
                ((a_full_q && (a_addr_q == ReadAdd1)) ||
                 (b_full_q && (b_addr_q == ReadAdd1)) ||
                 (write_en_q && (write_add_q == ReadAdd1)));
    pend_hit2 = (ReadAdd2 != 5'd0) &&
                ((a_full_q && (a_addr_q == ReadAdd2)) ||
                 (b_full_q && (b_addr_q == ReadAdd2)) ||
                 (write_en_q && (write_add_q == ReadAdd2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue/timestamp reference model.
// Inputs change 1 time unit after the falling edge; outputs are compared 2 units after it.
// Build option: WB_RR_EN selects round-robin expectations, matching the design build.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready;
  logic        write_en;
  logic [4:0]  WriteAdd;
  logic [31:0] Reg_WriteData;
  logic [4:0]  ReadAdd1 = '0, ReadAdd2 = '0;
  logic        pend_hit1, pend_hit2, busy;
  logic [15:0] wr_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .write_en(write_en), .WriteAdd(WriteAdd), .Reg_WriteData(Reg_WriteData),
    .ReadAdd1(ReadAdd1), .ReadAdd2(ReadAdd2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .busy(busy), .wr_count(wr_count)
  );

  // Stand-in for register_set: captures whatever the write port presents.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (write_en) rf[WriteAdd] <= Reg_WriteData;
  end

  // Reference model: index 0 = A, 1 = B; each slot remembers the cycle it was filled.
  bit          m_v [2] = '{0, 0};
  logic [4:0]  m_a [2] = '{5'd0, 5'd0};
  logic [31:0] m_d [2] = '{32'd0, 32'd0};
  int          m_t [2] = '{0, 0};
  int          m_last = 0;
  bit          m_wen = 0;
  logic [4:0]  m_wadd = '0;
  logic [31:0] m_wdat = '0;
  logic [15:0] m_cnt = '0;
  int          m_cyc = 0;
  int          m_g;
  bit          m_rdy0, m_rdy1;

  function automatic int pick();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_t[0] < m_t[1]) ? 0 : 1;
`ifdef WB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic bit pend_exp(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m_v[0] && m_a[0] == r) || (m_v[1] && m_a[1] == r) || (m_wen && m_wadd == r);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v[0] = 0; m_v[1] = 0;
      m_wen = 0; m_wadd = '0; m_wdat = '0; m_cnt = '0; m_last = 0;
    end else begin
      m_g    = pick();
      m_rdy0 = !m_v[0] || (m_g == 0);
      m_rdy1 = !m_v[1] || (m_g == 1);
      m_cnt  = m_cnt + 16'(m_wen);
      if (m_g >= 0) begin
        m_wen = 1; m_wadd = m_a[m_g]; m_wdat = m_d[m_g];
        m_v[m_g] = 0; m_last = m_g;
      end else begin
        m_wen = 0;
      end
      if (a_valid && m_rdy0 && a_addr != 5'd0) begin
        m_v[0] = 1; m_a[0] = a_addr; m_d[0] = a_data; m_t[0] = m_cyc;
      end
      if (b_valid && m_rdy1 && b_addr != 5'd0) begin
        m_v[1] = 1; m_a[1] = b_addr; m_d[1] = b_data; m_t[1] = m_cyc;
      end
      m_cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every cycle: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("wr_port", {write_en, WriteAdd, Reg_WriteData}, {m_wen, m_wadd, m_wdat});
      check("ready", {a_ready, b_ready},
            {!m_v[0] || (pick() == 0), !m_v[1] || (pick() == 1)});
      check("pend", {pend_hit1, pend_hit2}, {pend_exp(ReadAdd1), pend_exp(ReadAdd2)});
      check("busy", busy, m_v[0] || m_v[1] || m_wen);
      check("wr_count", wr_count, m_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && busy; i++) tick();
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_wen", write_en, 1'b0);
    check("rst_wadd", WriteAdd, 5'd0);
    check("rst_wdat", Reg_WriteData, 32'd0);
    check("rst_cnt", wr_count, 16'd0);
    check("rst_ready", {a_ready, b_ready}, 2'b11);

    // Transfers during reset are lost.
    a_valid = 1; a_addr = 5'd9; a_data = 32'h99; b_valid = 1; b_addr = 5'd9; b_data = 32'h98;
    tick();
    check("rst_lost_busy", busy, 1'b0);
    check("rst_lost_ready", {a_ready, b_ready}, 2'b11);

    // Release together with a transfer: accepted at the first edge, written two edges later.
    rst_n = 1; a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF; b_valid = 0;
    tick();
    a_valid = 0;
    check("lat1_wen", write_en, 1'b0);
    check("lat1_busy", busy, 1'b1);
    tick();
    check("lat2_wport", {write_en, WriteAdd, Reg_WriteData}, {1'b1, 5'd5, 32'hDEADBEEF});
    tick();
    check("lat3_cnt", wr_count, 16'd1);
    check("lat3_wen", write_en, 1'b0);

    // Simultaneous fill, distinct registers: B first, then A.
    a_valid = 1; a_addr = 5'd3; a_data = 32'h11111111;
    b_valid = 1; b_addr = 5'd4; b_data = 32'h22222222;
    tick();
    a_valid = 0; b_valid = 0;
    check("both_wait", write_en, 1'b0);
    tick();
    check("both_first", {write_en, WriteAdd, Reg_WriteData}, {1'b1, 5'd4, 32'h22222222});
    tick();
    check("both_second", {write_en, WriteAdd, Reg_WriteData}, {1'b1, 5'd3, 32'h11111111});
    tick();
    check("both_idle", {write_en, busy}, 2'b00);

    // Both requesters held valid for 8 edges.
    a_valid = 1; a_addr = 5'd10; b_valid = 1; b_addr = 5'd20;
    a_data = 32'hA0000000; b_data = 32'hB0000000;
    for (int k = 1; k <= 9; k++) begin
      tick();
      a_data = 32'hA0000000 | k; b_data = 32'hB0000000 | k;
      if (k >= 2) begin
`ifdef WB_RR_EN
        check("hold_port", {write_en, WriteAdd}, {1'b1, ((k - 2) % 2 == 0) ? 5'd20 : 5'd10});
`else
        check("hold_port", {write_en, WriteAdd}, {1'b1, 5'd20});
`endif
      end
`ifndef WB_RR_EN
      if (k <= 8) check("hold_a_stall", a_ready, 1'b0);
`endif
      if (k == 8) begin a_valid = 0; b_valid = 0; end
    end
    drain();
    check("hold_cnt", wr_count, 16'd12);

    // x0 writes are swallowed.
    b_valid = 1; b_addr = 5'd0; b_data = 32'hFFFFFFFF; ReadAdd1 = 5'd0;
    #1;
    check("x0_ready", b_ready, 1'b1);
    check("x0_pend", pend_hit1, 1'b0);
    tick();
    b_valid = 0;
    check("x0_idle", {write_en, busy}, 2'b00);
    tick();
    check("x0_wen", write_en, 1'b0);
    check("x0_cnt", wr_count, 16'd12);

    // Same register from A then B one edge later: A's data lands first, B's survives.
    ReadAdd1 = 5'd7;
    a_valid = 1; a_addr = 5'd7; a_data = 32'hA7A7A7A7;
    tick();
    a_valid = 0;
    b_valid = 1; b_addr = 5'd7; b_data = 32'hB7B7B7B7;
    check("raw_pend0", pend_hit1, 1'b1);
    tick();
    b_valid = 0;
    check("raw_first", {write_en, WriteAdd, Reg_WriteData}, {1'b1, 5'd7, 32'hA7A7A7A7});
    check("raw_pend1", pend_hit1, 1'b1);
    tick();
    check("raw_second", {write_en, WriteAdd, Reg_WriteData}, {1'b1, 5'd7, 32'hB7B7B7B7});
    check("raw_pend2", pend_hit1, 1'b1);
    tick();
    check("raw_done", {write_en, pend_hit1}, 2'b00);
    check("raw_rf", rf[7], 32'hB7B7B7B7);
    ReadAdd1 = 5'd0;

    // Reset in the middle of a busy cycle.
    a_valid = 1; a_addr = 5'd12; a_data = 32'hC0C0C0C0;
    b_valid = 1; b_addr = 5'd13; b_data = 32'hD0D0D0D0;
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    check("mid_wen_before", write_en, 1'b1);
    #2 rst_n = 0;
    #1;
    check("mid_wen_drop", write_en, 1'b0);
    check("mid_busy", busy, 1'b0);
    tick();
    rst_n = 1;
    tick();
    check("mid_after", {write_en, busy, a_ready, b_ready}, 4'b0011);
    tick();
    check("mid_after2", {write_en, busy}, 2'b00);
    check("mid_cnt", wr_count, 16'd0);
    check("mid_rf12", rf[12], 32'h0);

    // Randomized traffic with small address range to force collisions and x0 drops.
    for (int i = 0; i < 800; i++) begin
      a_valid  = ($urandom_range(3) != 0);
      b_valid  = ($urandom_range(3) != 0);
      a_addr   = 5'($urandom_range(5));
      b_addr   = 5'($urandom_range(5));
      a_data   = $urandom;
      b_data   = $urandom;
      ReadAdd1 = 5'($urandom_range(5));
      ReadAdd2 = 5'($urandom_range(5));
      rst_n    = ($urandom_range(299) != 0);
      tick();
    end
    rst_n = 1; a_valid = 0; b_valid = 0;
    tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; every flop samples on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports a_valid (input, 1), a_addr (input, 5), a_data (input, 32) and a_ready (output, 1): the ALU writeback requester, port A.
REQ-004 The block SHALL have the ports b_valid (input, 1), b_addr (input, 5), b_data (input, 32) and b_ready (output, 1): the load/MEM writeback requester, port B.
REQ-005 The block SHALL have the outputs write_en (1), WriteAdd (5) and Reg_WriteData (32), which drive the same-named inputs of register_set.
REQ-006 The block SHALL have the inputs ReadAdd1 and ReadAdd2 (5 bits each), which are copies of the register_set read addresses.
REQ-007 The block SHALL have the outputs pend_hit1 and pend_hit2 (1 bit each): a write to ReadAdd1 or ReadAdd2 is still pending.
REQ-008 The block SHALL have the outputs busy (1 bit: any write is in flight) and wr_count (16 bits: number of writes issued).

Function
REQ-009 Each port SHALL have a one-entry holding slot (valid flag, 5-bit address, 32-bit data).
REQ-010 x_ready SHALL equal (slot empty) OR (slot granted this cycle), decoded only from registered state and never from x_valid.
REQ-011 A transfer SHALL occur at an edge where x_valid and x_ready are both 1; the slot then loads x_addr and x_data.
REQ-012 A transfer with x_addr == 0 SHALL be accepted but discarded: the slot stays empty or drains normally, and no write is issued.
REQ-013 On each edge where at least one slot is full, exactly one full slot SHALL be granted.
REQ-014 The granted slot's address and data SHALL be registered into WriteAdd and Reg_WriteData, with write_en=1, for exactly one cycle.
REQ-015 If no slot is full, write_en SHALL be 0 on the next cycle, and WriteAdd and Reg_WriteData SHALL hold their previous values.
REQ-016 Latency: for a transfer at edge E into an empty slot with no contention, write_en SHALL be 1 during the cycle after edge E+1, and register_set SHALL write at edge E+2.
REQ-017 A granted slot SHALL clear at the grant edge unless a new transfer refills it at the same edge; a refill at that edge SHALL sustain one write per cycle per port.
REQ-018 Age rule: if both slots are full with equal addresses, the slot filled earlier SHALL be granted first, regardless of policy.
REQ-019 If both slots were filled at the same edge with equal addresses, B SHALL be granted first.
REQ-020 The age rule SHALL use a one-bit "A older" flag, updated on every fill.
REQ-021 Otherwise, when both slots are full, the grant SHALL follow the policy in REQ-026 and REQ-027.
REQ-022 pend_hit1 SHALL be 1 iff ReadAdd1 != 0 and ReadAdd1 matches a full slot address or, when write_en=1, WriteAdd.
REQ-023 pend_hit2 SHALL follow the rule of REQ-022, using ReadAdd2 in place of ReadAdd1.
REQ-024 busy SHALL equal (slot A full) OR (slot B full) OR write_en.
REQ-025 wr_count SHALL increment by 1 on each cycle write_en=1 and wrap from 0xFFFF to 0x0000; x0 drops SHALL NOT count.

Configuration
REQ-026 With macro WB_RR_EN defined, the both-full grant SHALL be round-robin: a last-grant pointer selects the port not granted most recently, and the pointer updates on every grant.
REQ-027 Without WB_RR_EN, the both-full grant SHALL be fixed priority with B over A, and A SHALL wait while B is continuously refilled.

Reset
REQ-028 While rst_n=0, asynchronously: both slots SHALL be empty, write_en=0, WriteAdd=0, Reg_WriteData=0, wr_count=0, the RR pointer SHALL point to "A granted last" (so B is next), and the age flag=0.
REQ-029 During reset, a_ready and b_ready SHALL be 1 (slots empty); transfers attempted during reset SHALL be lost.
REQ-030 Reset asserted mid-operation SHALL discard all pending slot contents, and the register file SHALL see no further write_en from them.
REQ-031 After rst_n rises, the first transfer SHALL be accepted at the first clk edge.

Verification
REQ-032 The bench SHALL drive a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle and check write_en=1, WriteAdd=5, Reg_WriteData=0xDEADBEEF exactly two edges later, then wr_count=1.
REQ-033 The bench SHALL drive A (addr 3, 0x11111111) and B (addr 4, 0x22222222) at the same edge and check that B writes first, then A on the next cycle, then busy=0.
REQ-034 The bench SHALL hold A and B valid for 8 cycles; with WB_RR_EN it SHALL check 8 alternating writes, and without it 8 B writes with a_ready=0 after the first A fill.
REQ-035 The bench SHALL drive b_addr=0, b_data=0xFFFFFFFF and check b_ready=1, write_en stays 0, wr_count unchanged, and pend_hit1=0 with ReadAdd1=0.
REQ-036 The bench SHALL fill A with addr 7, then B with addr 7 one edge later, and check that A's data is written first, then B's.
REQ-037 The bench SHALL check pend_hit1=1 with ReadAdd1=7 until the write_en cycle ends, and SHALL check that register_set then reads B's data.
REQ-038 The bench SHALL fill both slots, assert rst_n=0 mid-cycle, and check that write_en drops immediately, no write occurs, and the slots are empty after release.
